// File: rtl/safe_access_controller.sv
// Four-digit BCD code lock with attempt limiting, timed lockout and in-place code change.
// All outputs are registered from the next-state logic, so they track the state one edge after a push.
module safe_access_controller #(
   parameter int unsigned MAX_ATTEMPTS   = 3,
   parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       async_reset,
   input  logic       short_push,
   input  logic       long_push,
   input  logic [3:0] digit,
   output logic [7:0] seven_seg_output,
   output logic       unlocked,
   output logic       locked_out,
   output logic [1:0] entry_index
);

   typedef enum logic [2:0] {
      LOCKED, ENTRY, CHECK, OPEN, SET_NEW, LOCKOUT
   } state_t;

   localparam logic [3:0]  MAX_CNT  = 4'(MAX_ATTEMPTS);
   localparam logic [31:0] TIMER_LD = 32'(LOCKOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0][3:0]   code_q, code_d;
   logic [3:0][3:0]   entry_q, entry_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        att_q, att_d;
   logic [3:0]        att_inc;
   logic [31:0]       timer_q, timer_d;
   logic [7:0]        seg_q, seg_d;
   logic              unlocked_q, locked_out_q;
   logic              valid_short;
   logic              cap;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   assign valid_short = short_push && !long_push && (digit <= 4'd9);
   assign att_inc     = (att_q == 4'hF) ? att_q : att_q + 4'd1;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      entry_d = entry_q;
      idx_d   = idx_q;
      att_d   = att_q;
      timer_d = timer_q;
      cap     = 1'b0;
      case (state_q)
         LOCKED: begin
            if (valid_short) begin
               entry_d[0] = digit;
               idx_d      = 2'd1;
               cap        = 1'b1;
               state_d    = ENTRY;
            end
         end
         ENTRY, SET_NEW: begin
            if (long_push) begin
               idx_d   = 2'd0;
               state_d = (state_q == ENTRY) ? LOCKED : OPEN;
            end else if (valid_short) begin
               entry_d[idx_q] = digit;
               idx_d          = idx_q + 2'd1;
               cap            = 1'b1;
               if (idx_q == 2'd3) begin
                  if (state_q == ENTRY) begin
                     state_d = CHECK;
                  end else begin
                     code_d  = entry_d;
                     state_d = LOCKED;
                  end
               end
            end
         end
         CHECK: begin
            if (entry_q == code_q) begin
               att_d   = 4'd0;
               state_d = OPEN;
            end else begin
               att_d = att_inc;
               if (att_inc == MAX_CNT) begin
                  timer_d = TIMER_LD;
                  state_d = LOCKOUT;
               end else begin
                  state_d = LOCKED;
               end
            end
         end
         OPEN: begin
            // A short push of any digit value relocks, even an out-of-range one.
            if (long_push) begin
               idx_d   = 2'd0;
               state_d = SET_NEW;
            end else if (short_push) begin
               state_d = LOCKED;
            end
         end
         LOCKOUT: begin
            if (timer_q == 32'd0) begin
               att_d   = 4'd0;
               state_d = LOCKED;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         default: state_d = LOCKED;
      endcase

      seg_d = seg_q;
      case (state_d)
         LOCKED:  seg_d = 8'h38;
         CHECK:   seg_d = 8'h00;
         OPEN:    seg_d = 8'h3E;
         LOCKOUT: seg_d = 8'h40;
         default: begin
            // Nothing captured yet on entry to SET_NEW: show the dp alone.
            if (cap)
               seg_d = {1'b1, seg7(digit)};
            else if (state_d != state_q)
               seg_d = 8'h80;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (async_reset) begin
         state_q      <= LOCKED;
         code_q       <= '0;
         entry_q      <= '0;
         idx_q        <= 2'd0;
         att_q        <= 4'd0;
         timer_q      <= 32'd0;
         seg_q        <= 8'h38;
         unlocked_q   <= 1'b0;
         locked_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         entry_q      <= entry_d;
         idx_q        <= idx_d;
         att_q        <= att_d;
         timer_q      <= timer_d;
         seg_q        <= seg_d;
         unlocked_q   <= (state_d == OPEN);
         locked_out_q <= (state_d == LOCKOUT);
      end
   end

   assign seven_seg_output = seg_q;
   assign unlocked         = unlocked_q;
   assign locked_out       = locked_out_q;
   assign entry_index      = idx_q;

endmodule

// File: tb/tb_safe_access_controller.sv
// Directed bench for safe_access_controller with a 16-cycle lockout.
module tb_safe_access_controller;

   logic       clk = 1'b0;
   logic       async_reset = 1'b1;
   logic       short_push = 1'b0;
   logic       long_push = 1'b0;
   logic [3:0] digit = 4'd0;
   logic [7:0] seven_seg_output;
   logic       unlocked;
   logic       locked_out;
   logic [1:0] entry_index;

   int checks = 0;
   int errors = 0;

   safe_access_controller #(.MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(16)) dut (
      .clk              (clk),
      .async_reset      (async_reset),
      .short_push       (short_push),
      .long_push        (long_push),
      .digit            (digit),
      .seven_seg_output (seven_seg_output),
      .unlocked         (unlocked),
      .locked_out       (locked_out),
      .entry_index      (entry_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      short_push = 1'b1;
      digit      = d;
      tick();
      short_push = 1'b0;
   endtask

   task automatic hold();
      long_push = 1'b1;
      tick();
      long_push = 1'b0;
   endtask

   // Four digits then the CHECK cycle.
   task automatic enter_code(input logic [3:0] a, b, c, d);
      press(a); press(b); press(c); press(d);
      tick();
   endtask

   int n;

   initial begin
      // Pushes during reset must be ignored.
      short_push = 1'b1;
      digit      = 4'd1;
      tick(); tick();
      async_reset = 1'b0;
      short_push  = 1'b0;
      tick();
      check("rst_seg", 32'(seven_seg_output), 32'h38);
      check("rst_unlocked", 32'(unlocked), 32'd0);
      check("rst_locked_out", 32'(locked_out), 32'd0);
      check("rst_idx", 32'(entry_index), 32'd0);

      // Default code 0000, CHECK visible for one cycle.
      press(4'd0);
      check("entry1_idx", 32'(entry_index), 32'd1);
      check("entry1_seg", 32'(seven_seg_output), 32'hBF);
      press(4'd0); press(4'd0);
      check("entry3_idx", 32'(entry_index), 32'd3);
      press(4'd0);
      check("check_seg", 32'(seven_seg_output), 32'h00);
      check("check_idx", 32'(entry_index), 32'd0);
      press(4'd7);   // ignored during CHECK
      check("open_unlocked", 32'(unlocked), 32'd1);
      check("open_seg", 32'(seven_seg_output), 32'h3E);

      // Change code to 5678.
      hold();
      check("setnew_unlocked", 32'(unlocked), 32'd0);
      check("setnew_idx", 32'(entry_index), 32'd0);
      press(4'd5);
      check("setnew_seg5", 32'(seven_seg_output), 32'hED);
      press(4'd6); press(4'd7);
      check("setnew_seg7", 32'(seven_seg_output), 32'h87);
      press(4'd8);
      check("setnew_done_seg", 32'(seven_seg_output), 32'h38);
      enter_code(4'd0, 4'd0, 4'd0, 4'd0);
      check("old_code_rejected", 32'(unlocked), 32'd0);
      check("old_code_seg", 32'(seven_seg_output), 32'h38);
      enter_code(4'd5, 4'd6, 4'd7, 4'd8);
      check("new_code_unlocks", 32'(unlocked), 32'd1);
      press(4'd3);
      check("open_short_relocks", 32'(seven_seg_output), 32'h38);

      // Abort mid-entry, then two wrong codes: no lockout yet if abort and
      // the earlier success left the attempt counter alone / cleared.
      press(4'd1); press(4'd2);
      check("abort_pre_idx", 32'(entry_index), 32'd2);
      hold();
      check("abort_idx", 32'(entry_index), 32'd0);
      check("abort_seg", 32'(seven_seg_output), 32'h38);
      enter_code(4'd1, 4'd2, 4'd3, 4'd4);
      enter_code(4'd1, 4'd2, 4'd3, 4'd4);
      check("two_wrong_no_lockout", 32'(locked_out), 32'd0);
      enter_code(4'd1, 4'd2, 4'd3, 4'd4);
      check("third_wrong_lockout", 32'(locked_out), 32'd1);
      check("lockout_seg", 32'(seven_seg_output), 32'h40);
      n = 0;
      while (locked_out && n < 100) begin
         short_push = 1'b1;
         long_push  = n[0];
         digit      = 4'($urandom_range(0, 9));
         n++;
         tick();
      end
      short_push = 1'b0;
      long_push  = 1'b0;
      check("lockout_cycles", 32'(n), 32'd16);
      check("post_lockout_seg", 32'(seven_seg_output), 32'h38);
      check("post_lockout_idx", 32'(entry_index), 32'd0);
      enter_code(4'd5, 4'd6, 4'd7, 4'd8);
      check("post_lockout_unlock", 32'(unlocked), 32'd1);

      // SET_NEW abort keeps the code.
      hold();
      press(4'd9); press(4'd9); press(4'd9);
      hold();
      check("setnew_abort_open", 32'(unlocked), 32'd1);
      check("setnew_abort_seg", 32'(seven_seg_output), 32'h3E);
      press(4'd0);
      enter_code(4'd5, 4'd6, 4'd7, 4'd8);
      check("code_unchanged", 32'(unlocked), 32'd1);
      press(4'd0);

      // Invalid digit ignored; simultaneous pushes abort.
      press(4'hC);
      check("invalid_seg", 32'(seven_seg_output), 32'h38);
      check("invalid_idx", 32'(entry_index), 32'd0);
      press(4'd1);
      check("valid_after_invalid", 32'(entry_index), 32'd1);
      short_push = 1'b1;
      long_push  = 1'b1;
      digit      = 4'd2;
      tick();
      short_push = 1'b0;
      long_push  = 1'b0;
      check("both_push_idx", 32'(entry_index), 32'd0);
      check("both_push_seg", 32'(seven_seg_output), 32'h38);

      // Reset mid-lockout restores default code.
      enter_code(4'd5, 4'd6, 4'd7, 4'd8);
      hold();
      press(4'd1); press(4'd3); press(4'd5); press(4'd7);
      enter_code(4'd0, 4'd0, 4'd0, 4'd0);
      enter_code(4'd0, 4'd0, 4'd0, 4'd0);
      enter_code(4'd0, 4'd0, 4'd0, 4'd0);
      check("second_lockout", 32'(locked_out), 32'd1);
      tick(); tick(); tick();
      async_reset = 1'b1;
      tick();
      async_reset = 1'b0;
      check("reset_lockout_cleared", 32'(locked_out), 32'd0);
      check("reset_lockout_seg", 32'(seven_seg_output), 32'h38);
      enter_code(4'd0, 4'd0, 4'd0, 4'd0);
      check("reset_default_code", 32'(unlocked), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
